// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the rv32 fetch stage: FIFO entry layout and constants.
package fetch_unit_pkg;

    // addi x0, x0, 0 -- presented to decode whenever no fetched word is valid
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO with first-word fall-through: when empty, the word
// being pushed is visible at the head in the same cycle and can be popped
// without ever being stored.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          clear,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_valid = !empty || push;
    assign head       = empty ? push_data : mem_q[rd_ptr_q];

    // A push that is popped straight through an empty FIFO is never stored;
    // clear wins over both push and pop.
    always_comb begin
        wr_en    = push && !clear && !(empty && pop);
        rd_en    = pop && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rv32 instruction fetch stage: owns the fetch PC, issues credit-limited
// requests to instruction memory, buffers responses with their PCs and
// squashes everything in flight on a redirect from execute.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_ready,
    output logic [31:0] instr_f,
    output logic [31:0] pc_f
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          active_q, active_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;
    logic          accept;
    logic          rsp;
    logic          keep;
    logic          pop;
    logic          head_valid;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Requests only go out while buffered plus in-flight words leave room in
    // the FIFO, so every response is guaranteed a slot. The first cycle after
    // reset is kept idle so the request line is low throughout reset.
    always_comb begin
        in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req  = active_q && !redirect_valid && (in_use < (CW+1)'(DEPTH));
        imem_addr = fetch_pc_q;
        accept    = imem_req && imem_gnt;
        rsp       = imem_rvalid && active_q;
        keep      = rsp && !redirect_valid && (drop_cnt_q == '0);
        pop       = instr_ready && !stall_f;
    end

    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (keep),
        .push_data  (push_entry),
        .pop        (pop),
        .clear      (redirect_valid),
        .head       (head),
        .head_valid (head_valid),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Decode sees nothing during a redirect cycle; otherwise the FIFO head.
    always_comb begin
        instr_ready = head_valid && !redirect_valid;
        instr_f     = instr_ready ? head.instr : NOP_INSTR;
        pc_f        = instr_ready ? head.pc    : 32'h0;
    end

    // Next-state for PC, response-PC and credit/drop bookkeeping. On a
    // redirect every request still in flight after this edge is stale, and
    // an rvalid arriving in the redirect cycle itself is simply discarded.
    always_comb begin
        active_d      = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            drop_cnt_d = outstanding_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (keep)   resp_pc_d  = resp_pc_q + 32'd4;
            if (rsp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            active_q      <= active_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Credit invariant: in-flight plus buffered words never exceed the FIFO.
    a_credit: assert property (@(posedge clk) disable iff (!rst_n)
        in_use <= (CW+1)'(DEPTH));

    // A kept response must never find the FIFO full unless the head leaves.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(keep && !pop && (fifo_count == CW'(DEPTH))));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the rv32 pipeline; sits directly upstream of decode and feeds the hazard unit's instr_ready input.
- Holds the fetch PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs in a small in-order prefetch FIFO.
- Obeys stall_f from the hazard unit; on redirect from execute, squashes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- DEPTH, 2, FIFO entries; also the maximum number of outstanding imem requests (credit limit); power of two, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall_f  in  1  hazard stall; 1 = decode does not consume this cycle
- redirect_valid  in  1  taken branch/jump resolved in execute
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0)
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; responses arrive in order, >=1 cycle after gnt
- imem_rdata  in  32  instruction word
- instr_ready  out  1  FIFO head valid
- instr_f  out  32  head instruction; NOP_INSTR when empty
- pc_f  out  32  head PC; 0 when empty

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req=0, instr_ready=0, instr_f=32'h0000_0013, pc_f=0.
- Credit: imem_req=1 iff (fifo_count + outstanding) < DEPTH and redirect_valid=0. imem_addr=fetch_pc.
- Accept: req&&gnt -> fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0); outstanding++.
- Request stability: while req=1 and gnt=0, imem_addr is held stable. The only retraction allowed is a redirect, which drops an ungranted request; the memory side acts only on gnt.
- Response: rvalid -> outstanding--.
  - drop_cnt>0: data discarded, drop_cnt--.
  - Otherwise: push {pc, rdata} into the FIFO. The push PC comes from a response-PC register advanced by 4 per kept response.
- Pop: instr_ready && !stall_f. The head advances at the clock edge. instr_f/pc_f are combinational from the FIFO head (zero-latency first-word fall-through).
- Latency: gnt at cycle N, rvalid at N+1 -> instr_ready at N+1 (push bypasses to output when the FIFO is empty).
- Redirect (redirect_valid=1 in cycle N):
  - FIFO cleared at edge N.
  - drop_cnt <= outstanding_next. This counts a request granted in cycle N (impossible, req=0) and excludes an rvalid consumed in cycle N.
  - fetch_pc and response-PC register <= {redirect_pc[31:2],2'b00}.
  - instr_ready forced 0 in cycle N. No pop in cycle N.
  - Request for the target issued at N+1.
- Simultaneous events:
  - push+pop same cycle on a full FIFO is legal; count unchanged.
  - rvalid in the redirect cycle is discarded and not counted into drop_cnt.
  - Back-to-back redirects: the later one wins; drop_cnt recomputed from outstanding.
- Invariant: outstanding + fifo_count <= DEPTH, so a push never finds the FIFO full. An assertion flags violation.
- Arithmetic: outstanding, drop_cnt and fifo_count are $clog2(DEPTH)+1 bits. Pointers wrap mod DEPTH.

Decomposition:
- Shared package (defs.svh):
  - NOP_INSTR = 32'h0000_0013.
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}.
  - RESET_PC default constant.
- Sub-module fetch_fifo:
  - Parameterised DEPTH, entry type fetch_entry_t.
  - Ports: push, pop, clear, head, empty, count.
  - Clear has priority over push.
- fetch_unit holds the PC, credit/outstanding/drop counters and handshake logic.

Test Plan:
- Reset with RESET_PC=0x100, gnt=1, 1-cycle rvalid, stall_f=0 -> addresses 0x100,0x104,0x108 back-to-back. instr_ready from cycle 2; pc_f follows the same sequence, one per cycle.
- stall_f=1 held 5 cycles after 2 words buffered -> imem_req drops to 0 (credit exhausted). pc_f/instr_f stable. On release, sequence continues with no gap or duplicate.
- gnt=0 for 3 cycles -> imem_req=1 with imem_addr constant. No fetch_pc advance; instr_ready=0 once the FIFO drains.
- Two requests outstanding, redirect_pc=0x2003 -> both stale responses discarded. Next request addr=0x2000. First delivered pc_f=0x2000.
- redirect_valid coinciding with rvalid of 0x108 and one more outstanding -> 0x108 never appears. drop_cnt=1; the next rvalid is dropped; then target delivered.
- Assert rst_n=0 mid-burst with outstanding=2 -> all outputs at reset values immediately. After release, fetch restarts at RESET_PC; late rvalids are ignored by the bench memory model.
